// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control and data in, register state and taps out.
// The ROT signal exists only when USR_ROTATE_EN is defined.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SIN_MSB;
  logic             SIN_LSB;
`ifdef USR_ROTATE_EN
  logic             ROT;
`endif
  logic [WIDTH-1:0] Q;
  logic             SOUT_LSB;
  logic             SOUT_MSB;
  logic [CW-1:0]    CNT;
  logic             DONE;

  modport master (
`ifdef USR_ROTATE_EN
    output ROT,
`endif
    output EN, MODE, D, SIN_MSB, SIN_LSB,
    input  Q, SOUT_LSB, SOUT_MSB, CNT, DONE
  );

  modport slave (
`ifdef USR_ROTATE_EN
    input  ROT,
`endif
    input  EN, MODE, D, SIN_MSB, SIN_LSB,
    output Q, SOUT_LSB, SOUT_MSB, CNT, DONE
  );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold / shift right / shift left / parallel load,
// with a saturating shift counter. Define USR_ROTATE_EN to add rotate-on-shift via ROT.
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CW        = $clog2(WIDTH + 1)
) (
  input logic                  CLK,
  input logic                  CLR_N,
  universal_shift_reg_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             msb_in;
  logic             lsb_in;
  logic [CW-1:0]    cnt_inc;

`ifdef USR_ROTATE_EN
  assign msb_in = bus.ROT ? q_q[0]       : bus.SIN_MSB;
  assign lsb_in = bus.ROT ? q_q[WIDTH-1] : bus.SIN_LSB;
`else
  assign msb_in = bus.SIN_MSB;
  assign lsb_in = bus.SIN_LSB;
`endif

  // Counts shift operations regardless of direction, pinned at WIDTH.
  assign cnt_inc = (cnt_q < CNT_MAX) ? cnt_q + CW'(1) : cnt_q;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (bus.EN == 1'b1) begin
      // Non-matching (including unknown) MODE values fall through to hold.
      case (bus.MODE)
        MODE_RIGHT: begin
          q_d   = {msb_in, q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        MODE_LEFT: begin
          q_d   = {q_q[WIDTH-2:0], lsb_in};
          cnt_d = cnt_inc;
        end
        MODE_LOAD: begin
          q_d   = bus.D;
          cnt_d = '0;
        end
        default: begin
          q_d   = q_q;
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.SOUT_LSB = q_q[0];
  assign bus.SOUT_MSB = q_q[WIDTH-1];
  assign bus.CNT      = cnt_q;
  assign bus.DONE     = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8): directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_universal_shift_reg;
  localparam int W = 8;

  logic clk;
  logic clr_n;
  int   n_tests;
  int   n_fail;
  int   m_q;
  int   m_cnt;

  universal_shift_reg_if #(.WIDTH(W)) bus ();

  universal_shift_reg #(.WIDTH(W)) dut (
    .CLK   (clk),
    .CLR_N (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_q"}, 32'(bus.Q), 32'(m_q));
    chk({tag, "_cnt"}, 32'(bus.CNT), 32'(m_cnt));
    chk({tag, "_done"}, 32'(bus.DONE), 32'(m_cnt == W));
    chk({tag, "_slsb"}, 32'(bus.SOUT_LSB), 32'(m_q & 1));
    chk({tag, "_smsb"}, 32'(bus.SOUT_MSB), 32'((m_q >> (W - 1)) & 1));
  endtask

  // One clock of stimulus; the model advances from the same inputs.
  task automatic step(input logic en, input logic [1:0] mode, input logic [7:0] d,
                      input logic smsb, input logic slsb, input logic rot, input string tag);
    int min_b;
    int lin_b;
    @(negedge clk);
    bus.EN      = en;
    bus.MODE    = mode;
    bus.D       = d;
    bus.SIN_MSB = smsb;
    bus.SIN_LSB = slsb;
`ifdef USR_ROTATE_EN
    bus.ROT     = rot;
    min_b = rot ? (m_q & 1) : int'(smsb);
    lin_b = rot ? ((m_q >> (W - 1)) & 1) : int'(slsb);
`else
    min_b = int'(smsb);
    lin_b = int'(slsb);
    if (rot) min_b = int'(smsb);
`endif
    @(posedge clk);
    #1;
    if (en) begin
      case (mode)
        2'b01: begin
          m_q   = (m_q >> 1) | (min_b << (W - 1));
          m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
        end
        2'b10: begin
          m_q   = ((m_q << 1) & ((1 << W) - 1)) | lin_b;
          m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
        end
        2'b11: begin
          m_q   = int'(d);
          m_cnt = 0;
        end
        default: ;
      endcase
    end
    check_model(tag);
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge arrives.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    m_q   = 0;
    m_cnt = 0;
    chk({tag, "_rst_q"}, 32'(bus.Q), 32'h0);
    chk({tag, "_rst_cnt"}, 32'(bus.CNT), 32'h0);
    chk({tag, "_rst_done"}, 32'(bus.DONE), 32'h0);
    #1;
    clr_n = 1'b1;
  endtask

  initial begin
    logic [7:0] seq_a5;
    logic [7:0] sin_bits;
    n_tests = 0;
    n_fail  = 0;
    m_q     = 0;
    m_cnt   = 0;
    clr_n   = 1'b0;
    bus.EN = 1'b0; bus.MODE = 2'b00; bus.D = '0; bus.SIN_MSB = 1'b0; bus.SIN_LSB = 1'b0;
`ifdef USR_ROTATE_EN
    bus.ROT = 1'b0;
`endif
    #12;
    check_model("por");
    clr_n = 1'b1;

    // 1: async reset while holding 0x5A, then load 0x3C
    step(1, 2'b11, 8'h5A, 0, 0, 0, "t1_load");
    chk("t1_q5a", 32'(bus.Q), 32'h5A);
    async_reset("t1");
    step(1, 2'b11, 8'h3C, 0, 0, 0, "t1_reload");
    chk("t1_q3c", 32'(bus.Q), 32'h3C);

    // 2: one right shift, one left shift from 0xA5
    step(1, 2'b11, 8'hA5, 0, 0, 0, "t2_load");
    step(1, 2'b01, 8'h00, 1, 0, 0, "t2_sr");
    chk("t2_sr_q", 32'(bus.Q), 32'hD2);
    chk("t2_sr_slsb", 32'(bus.SOUT_LSB), 32'h0);
    chk("t2_sr_cnt", 32'(bus.CNT), 32'h1);
    step(1, 2'b11, 8'hA5, 0, 0, 0, "t2_load2");
    step(1, 2'b10, 8'h00, 0, 0, 0, "t2_sl");
    chk("t2_sl_q", 32'(bus.Q), 32'h4A);
    chk("t2_sl_smsb", 32'(bus.SOUT_MSB), 32'h0);
    chk("t2_sl_cnt", 32'(bus.CNT), 32'h1);

    // 3: drain 0xA5 to the right, saturation, then load clears
    seq_a5 = 8'b1010_0101;
    step(1, 2'b11, 8'hA5, 0, 0, 0, "t3_load");
    for (int i = 0; i < 8; i++) begin
      chk("t3_sout_seq", 32'(bus.SOUT_LSB), 32'(seq_a5[i]));
      step(1, 2'b01, 8'h00, 0, 0, 0, "t3_sr");
      if (i < 7) chk("t3_done_early", 32'(bus.DONE), 32'h0);
    end
    chk("t3_q", 32'(bus.Q), 32'h00);
    chk("t3_cnt", 32'(bus.CNT), 32'h8);
    chk("t3_done", 32'(bus.DONE), 32'h1);
    step(1, 2'b01, 8'h00, 0, 0, 0, "t3_sr9");
    chk("t3_cnt_sat", 32'(bus.CNT), 32'h8);
    chk("t3_done_sat", 32'(bus.DONE), 32'h1);
    step(1, 2'b11, 8'h11, 0, 0, 0, "t3_reload");
    chk("t3_cnt_clr", 32'(bus.CNT), 32'h0);
    chk("t3_done_clr", 32'(bus.DONE), 32'h0);

    // 4: EN=0 blocks shifting
    step(1, 2'b11, 8'hFF, 0, 0, 0, "t4_load");
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b01, 8'h00, 0, 0, 0, "t4_hold");
      chk("t4_q", 32'(bus.Q), 32'hFF);
      chk("t4_cnt", 32'(bus.CNT), 32'h0);
    end
    step(1, 2'b00, 8'h00, 1, 1, 0, "t4_mode0");
    chk("t4_q_mode0", 32'(bus.Q), 32'hFF);

    // 5: serial-in from reset
    async_reset("t5");
    sin_bits = 8'b0101_0011;
    for (int i = 0; i < 8; i++) step(1, 2'b10, 8'h00, 0, sin_bits[i], 0, "t5_sl");
    chk("t5_q", 32'(bus.Q), 32'hCA);
    chk("t5_done", 32'(bus.DONE), 32'h1);

`ifdef USR_ROTATE_EN
    // 6: rotate left
    step(1, 2'b11, 8'hA5, 0, 0, 0, "t6_load");
    step(1, 2'b10, 8'h00, 0, 0, 1, "t6_rot1");
    chk("t6_q1", 32'(bus.Q), 32'h4B);
    for (int i = 0; i < 7; i++) step(1, 2'b10, 8'h00, 0, 0, 1, "t6_rot");
    chk("t6_q8", 32'(bus.Q), 32'hA5);
    chk("t6_done", 32'(bus.DONE), 32'h1);
`endif

    // Randomized operations against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rnd");
      end else begin
        step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with asynchronous clear, clock enable, parallel load, and left/right shifting with serial in/out. A shift counter reports when a full word has been shifted since the last load. Used as a generic PISO/SIPO/holding register in datapaths and serial links.

Parameters:
WIDTH, 8, register width in bits (legal range 2..32).
RESET_VAL, {WIDTH{1'b0}}, value forced onto Q during reset.
CW, $clog2(WIDTH+1), counter width (derived; do not override).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
CLR_N  input  1  asynchronous active-low reset.
EN  input  1  clock enable; 0 = hold all state.
MODE  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
D  input  WIDTH  parallel load data.
SIN_MSB  input  1  serial bit entering Q[WIDTH-1] on a right shift.
SIN_LSB  input  1  serial bit entering Q[0] on a left shift.
Q  output  WIDTH  register contents.
SOUT_LSB  output  1  Q[0], the bit leaving on the next right shift.
SOUT_MSB  output  1  Q[WIDTH-1], the bit leaving on the next left shift.
CNT  output  CW  shifts performed since the last load, saturating.
DONE  output  1  CNT == WIDTH.

Behaviour:
- Reset: CLR_N=0 asynchronously forces Q=RESET_VAL, CNT=0, DONE=0, independent of CLK. Deassertion takes effect from the next rising edge. Reset mid-shift discards the word.
- All registered updates occur on the rising CLK edge only when CLR_N=1 and EN=1. With EN=0, Q and CNT hold for any MODE.
- MODE=00: Q and CNT hold.
- MODE=01 (shift right): Q <= {SIN_MSB, Q[WIDTH-1:1]}.
- MODE=10 (shift left): Q <= {Q[WIDTH-2:0], SIN_LSB}.
- MODE=11 (load): Q <= D and CNT <= 0.
- CNT on a shift:
  - increments by 1 when CNT < WIDTH;
  - saturates at WIDTH, and further shifts still move Q.
- DONE is decoded from the CNT register and adds no latency. It is high on the cycle after the WIDTH-th shift edge and stays high until a load or reset.
- SOUT_LSB and SOUT_MSB are continuous taps of Q, with no added latency.
- Latency: one clock from input to Q for every operation.
- Mixed directions count as shifts: a left shift after right shifts increments CNT. CNT is a count of shift operations, not a net position.
- No X propagation: unknown MODE values are treated as hold.

Optional Feature:
Macro USR_ROTATE_EN.
- When defined:
  - an extra input port ROT (1 bit) exists;
  - with ROT=1, a right shift loads Q[0] into the MSB instead of SIN_MSB, and a left shift loads Q[WIDTH-1] into the LSB instead of SIN_LSB;
  - CNT and DONE behave exactly as for normal shifts;
  - ROT is ignored for MODE 00 and 11.
- When undefined: the ROT port is absent and only serial-input shifting exists.

Test Plan:
WIDTH=8 throughout.
1. CLR_N=0 between clock edges while Q=0x5A -> Q=0x00, CNT=0, DONE=0 immediately with no clock edge. After release, the next load of 0x3C gives Q=0x3C one edge later.
2. Load 0xA5, then one right shift with SIN_MSB=1 -> Q=0xD2, SOUT_LSB=0, CNT=1. Alternatively, load 0xA5 then one left shift with SIN_LSB=0 -> Q=0x4A, SOUT_MSB=0, CNT=1.
3. Load 0xA5, then 8 right shifts with SIN_MSB=0 -> SOUT_LSB sequence 1,0,1,0,0,1,0,1. After the 8th edge: Q=0x00, CNT=8, DONE=1. A 9th shift leaves CNT=8, DONE=1. A following load clears CNT to 0 and DONE to 0.
4. Load 0xFF, EN=0, MODE=01 for 5 cycles -> Q=0xFF, CNT=0 throughout. Set EN=1 with MODE=00 -> Q still 0xFF.
5. Serial-in: from reset, 8 left shifts feeding SIN_LSB = 1,1,0,0,1,0,1,0 -> Q=0xCA, DONE=1.
6. (USR_ROTATE_EN) Load 0xA5, ROT=1, one left shift -> Q=0x4B. Then 7 more left shifts -> Q=0xA5, DONE=1.
